// File: rtl/next_kms_pkg.sv
// Shared mode encodings and display state type for the NeXT KMS keycode LED display.
package next_kms_pkg;

  localparam logic [1:0] KMS_MODE_LOW   = 2'd0;
  localparam logic [1:0] KMS_MODE_SPLIT = 2'd1;
  localparam logic [1:0] KMS_MODE_LIVE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHOW_LO = 2'd1,
    ST_SHOW_HI = 2'd2
  } kms_state_e;

endpackage

// File: rtl/next_kms_keycode_led_if.sv
// Keycode/control inputs and LED/status outputs of the keycode LED display.
interface next_kms_keycode_led_if #(
  parameter int KEYCODE_W = 16,
  parameter int LED_W     = 6,
  parameter int OCC_W     = 3
);
  logic [KEYCODE_W-1:0] kc_in;
  logic                 kc_valid;
  logic [1:0]           mode;
  logic                 clear;
  logic [LED_W-1:0]     led_n;
  logic                 overflow;
  logic [OCC_W-1:0]     occupancy;

  modport master (
    output kc_in, kc_valid, mode, clear,
    input  led_n, overflow, occupancy
  );

  modport slave (
    input  kc_in, kc_valid, mode, clear,
    output led_n, overflow, occupancy
  );
endinterface

// File: rtl/next_kms_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry a wrap bit to tell full from empty.
module next_kms_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/next_kms_keycode_led.sv
// Queues keycode events and shows each on the active-low LEDs for a programmable hold time.
module next_kms_keycode_led
  import next_kms_pkg::*;
#(
  parameter int               KEYCODE_W      = 16,
  parameter int               LED_W          = 6,
  parameter int               DEPTH          = 4,
  parameter int               HOLD_CYCLES    = 27000000,
  parameter int               VALID_IS_LEVEL = 1,
  parameter logic [LED_W-1:0] IDLE_PATTERN   = LED_W'(6'b110011)
) (
  input  logic                  clk,
  input  logic                  rst,
  next_kms_keycode_led_if.slave bus
);
  localparam int F     = LED_W - 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  kms_state_e              r_state, w_state_n;
  logic [CNT_W-1:0]        r_cnt, w_cnt_n;
  logic [LED_W-1:0]        r_led, w_led_n;
  logic [F-1:0]            r_kc_hi, w_kc_hi_n;
  logic                    r_kc_valid_q;
  logic                    r_overflow;

  logic                    w_flush, w_event, w_live, w_split, w_live_ev;
  logic                    w_push, w_pop, w_full, w_empty;
  logic [KEYCODE_W-1:0]    w_fifo_dout;
  logic [$clog2(DEPTH):0]  w_count;
  logic                    w_unused_dout;

  assign w_flush   = rst | bus.clear;
  assign w_event   = (VALID_IS_LEVEL != 0) ? (bus.kc_valid & ~r_kc_valid_q) : bus.kc_valid;
  assign w_live    = (bus.mode == KMS_MODE_LIVE);
  assign w_split   = (bus.mode == KMS_MODE_SPLIT);
  assign w_live_ev = w_event & w_live;
  // Queued entries are held back while in LIVE and drain once the mode changes.
  assign w_pop     = (r_state == ST_IDLE) & ~w_empty & ~w_live;
  assign w_push    = w_event & ~w_live;
  assign w_unused_dout = ^w_fifo_dout;

  next_kms_sync_fifo #(.WIDTH(KEYCODE_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (w_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (bus.kc_in),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_led_n   = r_led;
    w_kc_hi_n = r_kc_hi;
    if (w_live_ev) begin
      w_kc_hi_n = bus.kc_in[KEYCODE_W-1 -: F];
      w_led_n   = {1'b1, bus.kc_in[F-1:0]};
      w_cnt_n   = CNT_LOAD;
      w_state_n = ST_SHOW_LO;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            w_kc_hi_n = w_fifo_dout[KEYCODE_W-1 -: F];
            w_led_n   = {1'b1, w_fifo_dout[F-1:0]};
            w_cnt_n   = CNT_LOAD;
            w_state_n = ST_SHOW_LO;
          end
        end
        ST_SHOW_LO: begin
          if (r_cnt == '0) begin
            if (w_split) begin
              w_led_n   = {1'b1, r_kc_hi};
              w_cnt_n   = CNT_LOAD;
              w_state_n = ST_SHOW_HI;
            end else begin
              w_led_n[LED_W-1] = 1'b0;
              w_state_n        = ST_IDLE;
            end
          end else begin
            w_cnt_n = r_cnt - 1'b1;
          end
        end
        ST_SHOW_HI: begin
          if (r_cnt == '0) begin
            w_led_n[LED_W-1] = 1'b0;
            w_state_n        = ST_IDLE;
          end else begin
            w_cnt_n = r_cnt - 1'b1;
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_kc_valid_q <= 1'b0;
    else     r_kc_valid_q <= bus.kc_valid;
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_led      <= IDLE_PATTERN;
      r_kc_hi    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_led   <= w_led_n;
      r_kc_hi <= w_kc_hi_n;
      if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
    end
  end

  assign bus.led_n     = ~r_led;
  assign bus.overflow  = r_overflow;
  assign bus.occupancy = w_count;
endmodule
